// File: rtl/his_bank_scheduler.sv
// rtl/his_bank_scheduler.sv - ping-pong accumulate/readout scheduler for two histogram RAM banks
// Issues increment, read and clear commands only; the RAM datapath lives outside this block.
module his_bank_scheduler #(
    parameter int NB       = 8,
    parameter int BIN_NUM  = 256,
    parameter int DATA_NUM = 2,
    parameter int ACQ_NUM  = 33333
) (
    input  logic          clk,
    input  logic          res,
    input  logic          en,
    input  logic          frame_start,
    input  logic          ev_valid,
    input  logic [NB-1:0] ev_bin,
    output logic          wr_bank,
    output logic          acc_en,
    output logic [NB-1:0] acc_addr,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          rd_bank,
    output logic [NB-1:0] rd_addr,
    output logic          rd_last,
    output logic          clr_en,
    output logic          clr_bank,
    output logic [NB-1:0] clr_addr,
    output logic          his_done,
    output logic          overrun,
    output logic          busy
);

    localparam int FW = (ACQ_NUM < 1) ? 1 : $clog2(ACQ_NUM + 1);
    localparam int EW = (DATA_NUM < 1) ? 1 : $clog2(DATA_NUM + 1);
    localparam logic [NB-1:0] LAST_ADDR = NB'(BIN_NUM - 1);
    localparam logic [FW-1:0] ACQ_MAX   = FW'(ACQ_NUM);
    localparam logic [EW-1:0] EV_MAX    = EW'(DATA_NUM);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ACQ,
        ST_SWAP,
        ST_WAIT_RD
    } state_t;

    typedef enum logic {
        RD_IDLE,
        RD_RUN
    } rd_state_t;

    state_t          state_q;
    rd_state_t       rd_state_q;
    logic [FW-1:0]   frame_cnt_q;
    logic [EW-1:0]   ev_cnt_q;
    logic            init_bank_q;
    logic [NB-1:0]   init_addr_q;

    logic            wr_bank_q;
    logic            acc_en_q;
    logic [NB-1:0]   acc_addr_q;
    logic            rd_valid_q;
    logic            rd_bank_q;
    logic [NB-1:0]   rd_addr_q;
    logic            rd_last_q;
    logic            clr_en_q;
    logic            clr_bank_q;
    logic [NB-1:0]   clr_addr_q;
    logic            his_done_q;
    logic            overrun_q;
    logic            busy_q;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q     <= ST_INIT;
            rd_state_q  <= RD_IDLE;
            frame_cnt_q <= '0;
            ev_cnt_q    <= EV_MAX;
            init_bank_q <= 1'b0;
            init_addr_q <= '0;
            wr_bank_q   <= 1'b0;
            acc_en_q    <= 1'b0;
            acc_addr_q  <= '0;
            rd_valid_q  <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_addr_q   <= '0;
            rd_last_q   <= 1'b0;
            clr_en_q    <= 1'b0;
            clr_bank_q  <= 1'b0;
            clr_addr_q  <= '0;
            his_done_q  <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            acc_en_q   <= 1'b0;
            clr_en_q   <= 1'b0;
            his_done_q <= 1'b0;
            busy_q     <= 1'b1;

            // Every accepted beat is zeroed in the RAM on the following cycle.
            if (rd_state_q == RD_RUN && rd_ready) begin
                clr_en_q   <= 1'b1;
                clr_bank_q <= rd_bank_q;
                clr_addr_q <= rd_addr_q;
                if (rd_last_q) begin
                    rd_valid_q <= 1'b0;
                    rd_last_q  <= 1'b0;
                    rd_state_q <= RD_IDLE;
                end else begin
                    rd_addr_q <= rd_addr_q + NB'(1);
                    rd_last_q <= (rd_addr_q + NB'(1) == LAST_ADDR);
                end
            end

            case (state_q)
                ST_INIT: begin
                    clr_en_q   <= 1'b1;
                    clr_bank_q <= init_bank_q;
                    clr_addr_q <= init_addr_q;
                    if (init_addr_q == LAST_ADDR) begin
                        init_addr_q <= '0;
                        init_bank_q <= 1'b1;
                        if (init_bank_q) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        init_addr_q <= init_addr_q + NB'(1);
                    end
                end
                ST_IDLE: begin
                    busy_q <= en;
                    if (en) begin
                        state_q     <= ST_ACQ;
                        frame_cnt_q <= '0;
                        ev_cnt_q    <= EV_MAX;
                    end
                end
                ST_ACQ: begin
                    // A strobe arriving after the last frame closes the acquisition.
                    if (frame_start) begin
                        if (frame_cnt_q < ACQ_MAX) begin
                            frame_cnt_q <= frame_cnt_q + FW'(1);
                            ev_cnt_q    <= '0;
                        end else begin
                            state_q <= ST_SWAP;
                        end
                    end else if (ev_valid && ev_cnt_q < EV_MAX) begin
                        acc_en_q   <= 1'b1;
                        acc_addr_q <= ev_bin;
                        ev_cnt_q   <= ev_cnt_q + EW'(1);
                    end
                end
                ST_SWAP: begin
                    if (rd_state_q == RD_RUN) begin
                        state_q   <= ST_WAIT_RD;
                        overrun_q <= 1'b1;
                    end else begin
                        wr_bank_q   <= ~wr_bank_q;
                        his_done_q  <= 1'b1;
                        rd_state_q  <= RD_RUN;
                        rd_bank_q   <= wr_bank_q;
                        rd_addr_q   <= '0;
                        rd_valid_q  <= 1'b1;
                        rd_last_q   <= (BIN_NUM == 1);
                        frame_cnt_q <= '0;
                        ev_cnt_q    <= EV_MAX;
                        state_q     <= en ? ST_ACQ : ST_IDLE;
                        busy_q      <= en;
                    end
                end
                ST_WAIT_RD: begin
                    if (rd_state_q == RD_IDLE) begin
                        state_q <= ST_SWAP;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign wr_bank  = wr_bank_q;
    assign acc_en   = acc_en_q;
    assign acc_addr = acc_addr_q;
    assign rd_valid = rd_valid_q;
    assign rd_bank  = rd_bank_q;
    assign rd_addr  = rd_addr_q;
    assign rd_last  = rd_last_q;
    assign clr_en   = clr_en_q;
    assign clr_bank = clr_bank_q;
    assign clr_addr = clr_addr_q;
    assign his_done = his_done_q;
    assign overrun  = overrun_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_his_bank_scheduler.sv
// tb/tb_his_bank_scheduler.sv - scoreboard bench for his_bank_scheduler
module tb_his_bank_scheduler;

    localparam int NB       = 3;
    localparam int BIN_NUM  = 8;
    localparam int DATA_NUM = 2;
    localparam int ACQ_NUM  = 3;

    logic          clk = 1'b0;
    logic          res = 1'b0;
    logic          en = 1'b0;
    logic          frame_start = 1'b0;
    logic          ev_valid = 1'b0;
    logic [NB-1:0] ev_bin = '0;
    logic          rd_ready = 1'b0;
    logic          wr_bank, acc_en, rd_valid, rd_bank, rd_last;
    logic          clr_en, clr_bank, his_done, overrun, busy;
    logic [NB-1:0] acc_addr, rd_addr, clr_addr;

    his_bank_scheduler #(
        .NB(NB), .BIN_NUM(BIN_NUM), .DATA_NUM(DATA_NUM), .ACQ_NUM(ACQ_NUM)
    ) dut (
        .clk(clk), .res(res), .en(en), .frame_start(frame_start),
        .ev_valid(ev_valid), .ev_bin(ev_bin), .wr_bank(wr_bank),
        .acc_en(acc_en), .acc_addr(acc_addr), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_bank(rd_bank), .rd_addr(rd_addr),
        .rd_last(rd_last), .clr_en(clr_en), .clr_bank(clr_bank),
        .clr_addr(clr_addr), .his_done(his_done), .overrun(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    bit init_phase = 1'b0;
    bit prev_beat = 1'b0;

    logic [NB:0]   acc_q[$];
    logic [NB+1:0] beat_q[$];
    logic [NB:0]   clr_q[$];
    bit            his_q[$];

    // Reference model: 0 idle, 1 acquiring, 2 waiting for readout after overrun
    int rd_mode = 0;
    int m_mode = 0;
    int m_frames = 0;
    int m_ev = DATA_NUM;
    bit m_wr = 1'b0;
    bit m_ovr = 1'b0;
    bit ovr_phase = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (acc_en) begin
            if (acc_q.size() == 0) chk("acc_unexpected", 1, 0);
            else chk("acc_bank_addr", int'({wr_bank, acc_addr}), int'(acc_q.pop_front()));
        end
        if (clr_en) begin
            if (!init_phase) chk("clr_after_beat", int'(prev_beat), 1);
            if (clr_q.size() == 0) chk("clr_unexpected", 1, 0);
            else chk("clr_bank_addr", int'({clr_bank, clr_addr}), int'(clr_q.pop_front()));
        end
        if (rd_valid) begin
            chk("rd_bank_vs_wr_bank", int'(rd_bank), int'(!wr_bank));
            if (rd_ready) begin
                if (beat_q.size() == 0) chk("beat_unexpected", 1, 0);
                else chk("beat_bank_last_addr", int'({rd_bank, rd_last, rd_addr}), int'(beat_q.pop_front()));
            end
        end
        if (his_done) begin
            if (his_q.size() == 0) chk("his_done_unexpected", 1, 0);
            else chk("his_done_wr_bank", int'(wr_bank), int'(his_q.pop_front()));
        end
        prev_beat <= rd_valid && rd_ready;
    end

    task automatic close_acq();
        for (int a = 0; a < BIN_NUM; a++) begin
            beat_q.push_back({m_wr, a == BIN_NUM - 1, a[NB-1:0]});
            clr_q.push_back({m_wr, a[NB-1:0]});
        end
        his_q.push_back(!m_wr);
        m_wr = !m_wr;
        if (ovr_phase) begin
            m_ovr = 1'b1;
            m_mode = 2;
        end else begin
            m_mode = en ? 1 : 0;
            m_frames = 0;
            m_ev = DATA_NUM;
        end
    endtask

    task automatic model(input bit fs, input bit ev, input int bin);
        if (m_mode == 1) begin
            if (fs) begin
                if (m_frames < ACQ_NUM) begin
                    m_frames++;
                    m_ev = 0;
                end else begin
                    close_acq();
                end
            end else if (ev && m_ev < DATA_NUM) begin
                acc_q.push_back({m_wr, bin[NB-1:0]});
                m_ev++;
            end
        end
    endtask

    task automatic drive(input bit fs, input bit ev, input int bin);
        frame_start = fs;
        ev_valid = ev;
        ev_bin = bin[NB-1:0];
        case (rd_mode)
            0: rd_ready = 1'b1;
            1: rd_ready = !rd_ready;
            2: rd_ready = 1'($urandom_range(0, 1));
            default: rd_ready = 1'b0;
        endcase
        model(fs, ev, bin);
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        ev_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 0);
    endtask

    task automatic wait_beats();
        int t = 0;
        while (beat_q.size() != 0 && t < 400) begin
            drive(1'b0, 1'b0, 0);
            t++;
        end
        chk("readout_drain", beat_q.size(), 0);
    endtask

    task automatic wait_his();
        int t = 0;
        while (his_q.size() != 0 && t < 100) begin
            drive(1'b0, 1'b0, 0);
            t++;
        end
        chk("his_done_seen", his_q.size(), 0);
    endtask

    task automatic acquisition(input bit directed, input int en_off_frame);
        drive(1'b0, 1'b1, int'($urandom_range(0, BIN_NUM - 1)));
        for (int f = 1; f <= ACQ_NUM; f++) begin
            if (directed) begin
                drive(1'b1, f == 1, 2);
                drive(1'b0, 1'b1, 5);
                drive(1'b0, 1'b1, 5);
                drive(1'b0, 1'b1, 7);
                idle(1);
            end else begin
                drive(1'b1, $urandom_range(0, 3) == 0, int'($urandom_range(0, BIN_NUM - 1)));
                repeat ($urandom_range(0, 4)) begin
                    drive(1'b0, 1'b1, int'($urandom_range(0, BIN_NUM - 1)));
                    idle(int'($urandom_range(0, 2)));
                end
            end
            if (f == en_off_frame) en = 1'b0;
        end
    endtask

    task automatic close(input bit drain_first);
        if (drain_first) wait_beats();
        idle(2);
        drive(1'b1, 1'b0, 0);
        idle(3);
    endtask

    task automatic release_reset();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < BIN_NUM; a++) begin
                logic bb;
                bb = b[0];
                clr_q.push_back({bb, a[NB-1:0]});
            end
        init_phase = 1'b1;
        res = 1'b1;
        idle(3);
        chk("busy_in_init", int'(busy), 1);
        idle(2 * BIN_NUM + 2);
        init_phase = 1'b0;
        chk("init_clears_done", clr_q.size(), 0);
        chk("busy_after_init", int'(busy), 0);
        chk("overrun_after_init", int'(overrun), 0);
    endtask

    task automatic start_acq();
        en = 1'b1;
        m_mode = 1;
        m_frames = 0;
        m_ev = DATA_NUM;
        idle(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_bank", int'(wr_bank), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_clr_en", int'(clr_en), 0);
        chk("rst_acc_en", int'(acc_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_his_done", int'(his_done), 0);
        release_reset();

        rd_mode = 0;
        start_acq();
        acquisition(1'b1, 0);
        close(1'b1);
        wait_beats();
        chk("wr_bank_after_first_swap", int'(wr_bank), 1);

        rd_mode = 1;
        acquisition(1'b0, 0);
        close(1'b1);
        wait_beats();

        rd_mode = 2;
        repeat (5) begin
            acquisition(1'b0, 0);
            close(1'b1);
        end
        wait_beats();
        chk("overrun_before_hold", int'(overrun), 0);

        rd_mode = 3;
        acquisition(1'b0, 0);
        close(1'b1);
        acquisition(1'b0, 0);
        ovr_phase = 1'b1;
        close(1'b0);
        ovr_phase = 1'b0;
        chk("overrun_set", int'(overrun), int'(m_ovr));
        drive(1'b1, 1'b0, 0);
        drive(1'b0, 1'b1, 4);
        drive(1'b0, 1'b1, 4);
        idle(2);
        chk("busy_in_wait_rd", int'(busy), 1);
        rd_mode = 0;
        wait_beats();
        wait_his();
        idle(3);
        m_mode = en ? 1 : 0;
        m_frames = 0;
        m_ev = DATA_NUM;
        chk("overrun_sticky", int'(overrun), 1);

        acquisition(1'b0, 2);
        close(1'b1);
        chk("busy_idle_after_en_off", int'(busy), 0);
        drive(1'b1, 1'b0, 0);
        drive(1'b0, 1'b1, 1);
        idle(2);
        start_acq();

        acquisition(1'b0, 0);
        rd_mode = 1;
        close(1'b1);
        idle(4);
        chk("wr_bank_before_reset", int'(wr_bank), int'(m_wr));
        res = 1'b0;
        #1;
        chk("reset_rd_valid", int'(rd_valid), 0);
        chk("reset_wr_bank", int'(wr_bank), 0);
        chk("reset_overrun", int'(overrun), 0);
        acc_q.delete();
        beat_q.delete();
        clr_q.delete();
        his_q.delete();
        en = 1'b0;
        m_mode = 0;
        m_wr = 1'b0;
        m_ovr = 1'b0;
        @(posedge clk);
        #1;
        release_reset();

        rd_mode = 2;
        start_acq();
        acquisition(1'b0, 0);
        close(1'b1);
        wait_beats();
        wait_his();
        idle(5);
        chk("final_acc_queue", acc_q.size(), 0);
        chk("final_clr_queue", clr_q.size(), 0);
        chk("final_overrun", int'(overrun), int'(m_ovr));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/his_bank_scheduler.md
Name: his_bank_scheduler

Overview:
Ping-pong controller for the two external histogram RAM banks of the dToF histogram builder. One bank accumulates TDC events over ACQ_NUM laser frames, capped at DATA_NUM events per frame. The other bank is streamed out over a valid/ready interface and cleared bin-by-bin during readout. The block issues increment, read and clear commands only; the RAM datapath is external.

Parameters:
NB, 8, bin address width
BIN_NUM, 256, bins per bank (≤ 2^NB)
DATA_NUM, 2, max accepted events per frame
ACQ_NUM, 33333, frames per acquisition (histogram)

Ports:
clk  in  1  clock
res  in  1  asynchronous active-low reset
en  in  1  run enable; sampled only in IDLE and SWAP
frame_start  in  1  laser frame start strobe
ev_valid  in  1  TDC event strobe
ev_bin  in  NB  event bin
wr_bank  out  1  bank being accumulated
acc_en  out  1  increment strobe to bank wr_bank
acc_addr  out  NB  increment address
rd_valid  out  1  read beat valid
rd_ready  in  1  consumer accepts beat
rd_bank  out  1  bank being read (always ~wr_bank while rd_valid)
rd_addr  out  NB  read address
rd_last  out  1  marks beat rd_addr == BIN_NUM-1
clr_en  out  1  write-zero strobe
clr_bank  out  1  bank for clr_en
clr_addr  out  NB  clear address
his_done  out  1  1-cycle pulse on bank swap
overrun  out  1  sticky: acquisition finished while readout busy
busy  out  1  state != IDLE

Behaviour:
- Reset (async, res=0): all outputs 0; frame_cnt=0; ev_cnt=DATA_NUM; main FSM=INIT; read FSM=RD_IDLE. Release → INIT.
- All outputs are registered. acc_en/acc_addr follow the accepted event by 1 cycle.
- Main FSM states: INIT, IDLE, ACQ, SWAP, WAIT_RD.
- INIT: clr_en=1 for 2*BIN_NUM cycles.
  - clr_bank=0 with clr_addr 0..BIN_NUM-1, then clr_bank=1 with clr_addr 0..BIN_NUM-1.
  - Then → IDLE. Events and frame_start are ignored.
- IDLE: en=1 → ACQ with frame_cnt=0, ev_cnt=DATA_NUM (events before the first frame_start are dropped).
- ACQ, frame_start=1 with frame_cnt<ACQ_NUM: frame_cnt++, ev_cnt=0.
- ACQ, frame_start=1 with frame_cnt==ACQ_NUM: closes the acquisition → SWAP. That strobe does not open a frame.
- ACQ, ev_valid=1 with ev_cnt<DATA_NUM and no frame_start that cycle: accept, i.e. acc_en=1 and acc_addr=ev_bin next cycle, ev_cnt++.
  - Otherwise the event is dropped.
  - frame_start and ev_valid in the same cycle: frame_start wins; the event is dropped.
- SWAP (1 cycle):
  - Read FSM busy: → WAIT_RD, overrun=1 (cleared only by reset).
  - Else: wr_bank toggles, his_done pulses, readout of the old bank starts. Next state is ACQ (frame_cnt=0, ev_cnt=DATA_NUM) if en=1, else IDLE.
- WAIT_RD: events and frame_start are dropped; acc_en=0. When the read FSM returns to RD_IDLE, perform the SWAP actions the next cycle.
- Read FSM states: RD_IDLE, RD_RUN.
- Start: rd_bank=old wr_bank, rd_addr=0, rd_valid=1, rd_last=(BIN_NUM==1).
- rd_valid=1 & rd_ready=0: rd_addr and rd_bank hold.
- rd_valid & rd_ready (accept): next cycle clr_en=1, clr_bank=rd_bank, clr_addr=accepted rd_addr.
  - Not last: rd_addr++.
  - Last: rd_valid=0, rd_last=0, → RD_IDLE.
- Invariant: acc_en and clr_en (outside INIT) never target the same bank.
- rd_addr and acc_addr never wrap mid-pass. The read pass is exactly BIN_NUM beats.
- Reset mid-operation: immediate return to reset values. External banks are re-zeroed by INIT.

Test Plan:
- BIN_NUM=8, ACQ_NUM=3, DATA_NUM=2. Release reset → clr_en high 16 cycles: bank 0 addr 0–7, then bank 1 addr 0–7; busy=0 after.
- en=1; 3 frames, each with events at bins 5, 5, 7 → acc_en pulses with addr 5,5 per frame (bin 7 dropped). 4th frame_start → his_done, wr_bank=1, rd_bank=0.
- Readout with rd_ready always 1 → rd_addr 0..7 on consecutive cycles, rd_last on addr 7, clr_en on bank 0 addr 0..7 each one cycle after its beat.
- rd_ready toggling 1/0 → each rd_addr held until accepted; exactly 8 beats, 8 clears.
- rd_ready=0 held through a full second acquisition → overrun=1, WAIT_RD, no acc_en. Release rd_ready → after the last beat, swap: wr_bank=0, his_done pulses.
- Event before first frame_start, and event coincident with frame_start → no acc_en. en=0 during ACQ → continues to SWAP then IDLE. res=0 mid-readout → rd_valid=0, wr_bank=0, INIT restarts.
